kbd_event_encoder: RTL

- Downstream of the keyboard matrix scanner. Consumes one row snapshot per driven column.
- Debounces every key across successive scan frames.
- Emits press/release events into a small event FIFO for the CPU-side register interface.
- Runs entirely in the main clock domain. The scanner hands over snapshots already synchronised to clk.

---
 rtl/kbd_event_if.sv | 28 ++
 rtl/kbd_event_encoder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/kbd_event_if.sv
// Snapshot and event bus between the matrix scanner, the key event encoder and the CPU-side
// register block. The master is the scanner/CPU side; the slave is the encoder.
interface kbd_event_if #(
  parameter int unsigned NUM_ROWS   = 9,
  parameter int unsigned FIFO_DEPTH = 16
);
  logic                          col_valid;
  logic                          col_ready;
  logic [3:0]                    col_idx;
  logic [NUM_ROWS-1:0]           row_bits;
  logic                          evt_valid;
  logic                          evt_ready;
  logic [8:0]                    evt_data;
  logic [$clog2(FIFO_DEPTH):0]   evt_count;
  logic                          overflow;
  logic                          ovf_clr;
  logic                          key_any;

  modport master (
    output col_valid, col_idx, row_bits, evt_ready, ovf_clr,
    input  col_ready, evt_valid, evt_data, evt_count, overflow, key_any
  );

  modport slave (
    input  col_valid, col_idx, row_bits, evt_ready, ovf_clr,
    output col_ready, evt_valid, evt_data, evt_count, overflow, key_any
  );
endinterface

// File: rtl/kbd_event_encoder.sv
// Per-key debounce of column snapshots from the matrix scanner; debounced state changes are
// queued as press/release events in a small FIFO for the CPU side.
module kbd_event_encoder #(
  parameter int unsigned NUM_ROWS   = 9,
  parameter int unsigned NUM_COLS   = 10,
  parameter int unsigned DEBOUNCE   = 3,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input logic          clk,
  input logic          rst,
  kbd_event_if.slave   bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StUpdate = 2'd1;
  localparam logic [1:0] StEmit   = 2'd2;

  localparam logic [3:0]          DebLimit = 4'(DEBOUNCE);
  localparam logic [NUM_ROWS-1:0] RowOne   = NUM_ROWS'(1);

  logic [1:0]                        state_q, state_d;
  logic [3:0]                        col_q;
  logic [NUM_ROWS-1:0]               row_q;
  logic [NUM_ROWS-1:0]               mask_q, mask_d;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0] stable_q, stable_d;
  logic [3:0]                        cnt_q [NUM_COLS][NUM_ROWS];
  logic [3:0]                        cnt_d [NUM_COLS][NUM_ROWS];
  logic                              key_any_q;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;

  logic          accept;
  logic          push_req, push, pop, full, ovf_set;
  logic [8:0]    push_data;
  logic [3:0]    low_idx;
  logic          low_press;

  assign accept = (state_q == StIdle) && bus.col_valid;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    push_req  = 1'b0;
    push_data = '0;
    low_idx   = '0;
    low_press = 1'b0;

    // Descending scan leaves the lowest pending row selected; its raw bit is the new state.
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (mask_q[r]) begin
        low_idx   = 4'(r);
        low_press = row_q[r];
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.col_valid) state_d = StUpdate;
      end
      StUpdate: begin
        mask_d = '0;
        // Out-of-range column indices match no column and leave all state untouched.
        for (int c = 0; c < NUM_COLS; c++) begin
          if (col_q == 4'(c)) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
              if (row_q[r] == stable_q[c][r]) begin
                cnt_d[c][r] = '0;
              end else if (cnt_q[c][r] + 4'd1 == DebLimit) begin
                stable_d[c][r] = row_q[r];
                cnt_d[c][r]    = '0;
                mask_d[r]      = 1'b1;
              end else begin
                cnt_d[c][r] = cnt_q[c][r] + 4'd1;
              end
            end
          end
        end
        state_d = (mask_d != '0) ? StEmit : StIdle;
      end
      StEmit: begin
        push_req  = 1'b1;
        push_data = {low_press, low_idx, col_q};
        mask_d    = mask_q & (mask_q - RowOne);
        if (mask_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = (count_q != '0) && bus.evt_ready;
  assign push    = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      mask_q     <= '0;
      stable_q   <= '0;
      cnt_q      <= '{default: '0};
      key_any_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      key_any_q <= |stable_d;
      if (accept) begin
        col_q <= bus.col_idx;
        row_q <= bus.row_bits;
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (ovf_set)          overflow_q <= 1'b1;
      else if (bus.ovf_clr) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= push_data;
  end

  assign bus.col_ready = (state_q == StIdle);
  assign bus.evt_valid = (count_q != '0);
  assign bus.evt_data  = mem_q[rd_ptr_q];
  assign bus.evt_count = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.key_any   = key_any_q;

endmodule
